// File: rtl/branch_pkg.sv
// Shared types for the branch resolve unit: op codes, FSM states, PC width.
package branch_pkg;

    localparam int PC_W = 20;

    typedef enum logic [2:0] {
        BR_BEQ = 3'd0,
        BR_BNE = 3'd1,
        BR_BS  = 3'd2,
        BR_BNS = 3'd3,
        BR_JMP = 3'd4
    } br_op_t;

    typedef enum logic [1:0] {
        BRS_IDLE,
        BRS_WAIT_FLAGS,
        BRS_RESOLVE,
        BRS_FLUSH
    } brs_state_t;

    // Only the four flag-testing ops consume the flag register.
    function automatic logic br_is_cond(logic [2:0] op);
        return op < 3'd4;
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: (op, Z, S) -> taken.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic       z_i,
    input  logic       s_i,
    output logic       taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            BR_BEQ:  taken_o = z_i;
            BR_BNE:  taken_o = !z_i;
            BR_BS:   taken_o = s_i;
            BR_BNS:  taken_o = !s_i;
            BR_JMP:  taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolve: flag register, resolve FSM, next-PC and flush generation.
// Optional BRANCH_STATS_EN adds saturating resolve/taken counters.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int WIDTH        = PC_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_valid,
    input  logic             flag_zero,
    input  logic             flag_sign,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_op,
    input  logic [WIDTH-1:0] br_pc,
    input  logic [WIDTH-1:0] br_target,
    output logic             pc_valid,
    output logic [WIDTH-1:0] pc_next,
    output logic             br_taken,
    output logic             flush
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]      stat_total,
    output logic [15:0]      stat_taken
`endif
);

    brs_state_t       state_q;
    logic             z_q, s_q, fresh_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] pc_q, tgt_q;
    logic [7:0]       cnt_q;
    logic             pc_valid_q, taken_q, flush_q;
    logic [WIDTH-1:0] pc_next_q;

    logic             idle, go_resolve;
    logic             z_eff, s_eff, taken_d;
    logic [2:0]       op_eff;
    logic [WIDTH-1:0] pc_eff, tgt_eff, pc_next_d;

    // Same-cycle flags bypass the register so they are "written then used".
    always_comb begin
        idle    = (state_q == BRS_IDLE);
        z_eff   = flag_valid ? flag_zero : z_q;
        s_eff   = flag_valid ? flag_sign : s_q;
        op_eff  = idle ? br_op : op_q;
        pc_eff  = idle ? br_pc : pc_q;
        tgt_eff = idle ? br_target : tgt_q;
        go_resolve = 1'b0;
        if (idle && br_valid)
            go_resolve = !br_is_cond(br_op) || fresh_q || flag_valid;
        else if (state_q == BRS_WAIT_FLAGS)
            go_resolve = flag_valid;
    end

    branch_cond_eval u_eval (
        .op_i    (op_eff),
        .z_i     (z_eff),
        .s_i     (s_eff),
        .taken_o (taken_d)
    );

    assign pc_next_d = taken_d ? tgt_eff : pc_eff + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BRS_IDLE;
            z_q        <= 1'b0;
            s_q        <= 1'b0;
            fresh_q    <= 1'b0;
            op_q       <= '0;
            pc_q       <= '0;
            tgt_q      <= '0;
            cnt_q      <= '0;
            pc_valid_q <= 1'b0;
            taken_q    <= 1'b0;
            flush_q    <= 1'b0;
            pc_next_q  <= '0;
        end else begin
            pc_valid_q <= 1'b0;
            if (flag_valid) begin
                z_q     <= flag_zero;
                s_q     <= flag_sign;
                fresh_q <= 1'b1;
            end
            if (go_resolve) begin
                pc_valid_q <= 1'b1;
                taken_q    <= taken_d;
                pc_next_q  <= pc_next_d;
            end
            case (state_q)
                BRS_IDLE: begin
                    if (br_valid) begin
                        op_q    <= br_op;
                        pc_q    <= br_pc;
                        tgt_q   <= br_target;
                        state_q <= go_resolve ? BRS_RESOLVE : BRS_WAIT_FLAGS;
                    end
                end
                BRS_WAIT_FLAGS: begin
                    if (go_resolve)
                        state_q <= BRS_RESOLVE;
                end
                BRS_RESOLVE: begin
                    if (br_is_cond(op_q) && !flag_valid)
                        fresh_q <= 1'b0;
                    if (taken_q && FLUSH_CYCLES > 0) begin
                        state_q <= BRS_FLUSH;
                        flush_q <= 1'b1;
                        cnt_q   <= 8'(FLUSH_CYCLES - 1);
                    end else begin
                        state_q <= BRS_IDLE;
                    end
                end
                BRS_FLUSH: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= BRS_IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= BRS_IDLE;
            endcase
        end
    end

    assign br_ready = idle;
    assign pc_valid = pc_valid_q;
    assign pc_next  = pc_next_q;
    assign br_taken = taken_q;
    assign flush    = flush_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_total_q, stat_taken_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_total_q <= '0;
            stat_taken_q <= '0;
        end else if (state_q == BRS_RESOLVE) begin
            if (stat_total_q != 16'hFFFF)
                stat_total_q <= stat_total_q + 16'd1;
            if (taken_q && stat_taken_q != 16'hFFFF)
                stat_taken_q <= stat_taken_q + 16'd1;
        end
    end

    assign stat_total = stat_total_q;
    assign stat_taken = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus random branches.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flag_valid, flag_zero, flag_sign;
    logic        br_valid, br_ready;
    logic [2:0]  br_op;
    logic [19:0] br_pc, br_target;
    logic        pc_valid;
    logic [19:0] pc_next;
    logic        br_taken, flush;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_total, stat_taken;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model of the flag register
    bit m_z, m_s, m_fresh;
    int m_total, m_taken;

    always #5 clk = ~clk;

    branch_resolve dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flag_valid (flag_valid),
        .flag_zero  (flag_zero),
        .flag_sign  (flag_sign),
        .br_valid   (br_valid),
        .br_ready   (br_ready),
        .br_op      (br_op),
        .br_pc      (br_pc),
        .br_target  (br_target),
        .pc_valid   (pc_valid),
        .pc_next    (pc_next),
        .br_taken   (br_taken),
        .flush      (flush)
`ifdef BRANCH_STATS_EN
        ,
        .stat_total (stat_total),
        .stat_taken (stat_taken)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_flags(input bit z, input bit s);
        flag_valid = 1'b1;
        flag_zero  = z;
        flag_sign  = s;
        m_z = z;
        m_s = s;
        m_fresh = 1'b1;
        tick();
        flag_valid = 1'b0;
    endtask

    function automatic bit ref_taken(input logic [2:0] op, input bit z, input bit s);
        if (op == 3'd0) return z;
        if (op == 3'd1) return !z;
        if (op == 3'd2) return s;
        if (op == 3'd3) return !s;
        return op == 3'd4;
    endfunction

    // One complete branch transaction, checked cycle by cycle.
    // sf: flags with the accept; wc: wait cycles before late flags;
    // rf: flags during the resolve cycle.
    task automatic do_branch(input logic [2:0] op, input logic [19:0] pc,
                             input logic [19:0] tgt,
                             input bit sf, input bit sz, input bit ss,
                             input int wc, input bit lz, input bit ls,
                             input bit rf, input bit rz, input bit rs);
        bit          cond, tk;
        logic [19:0] exp_pc;
        cond = (op < 3'd4);
        check("ready_before", br_ready, 1);
        br_valid  = 1'b1;
        br_op     = op;
        br_pc     = pc;
        br_target = tgt;
        if (sf) begin
            flag_valid = 1'b1;
            flag_zero  = sz;
            flag_sign  = ss;
            m_z = sz;
            m_s = ss;
            m_fresh = 1'b1;
        end
        tick();
        br_valid   = 1'b0;
        flag_valid = 1'b0;
        if (cond && !m_fresh) begin
            for (int i = 0; i < wc; i++) begin
                check("wait_pcv", pc_valid, 0);
                check("wait_rdy", br_ready, 0);
                tick();
            end
            check("wait_pcv", pc_valid, 0);
            flag_valid = 1'b1;
            flag_zero  = lz;
            flag_sign  = ls;
            m_z = lz;
            m_s = ls;
            m_fresh = 1'b1;
            tick();
            flag_valid = 1'b0;
        end
        tk = ref_taken(op, m_z, m_s);
        exp_pc = tk ? tgt : pc + 20'd1;
        check("pc_valid", pc_valid, 1);
        check("pc_next", pc_next, exp_pc);
        check("br_taken", br_taken, tk);
        check("rdy_resolve", br_ready, 0);
        check("flush_resolve", flush, 0);
        if (cond) m_fresh = 1'b0;
        if (rf) begin
            flag_valid = 1'b1;
            flag_zero  = rz;
            flag_sign  = rs;
            m_z = rz;
            m_s = rs;
            m_fresh = 1'b1;
        end
        m_total++;
        if (tk) m_taken++;
        tick();
        flag_valid = 1'b0;
        check("pcv_pulse", pc_valid, 0);
        check("pc_hold", pc_next, exp_pc);
        if (tk) begin
            repeat (2) begin
                check("flush_on", flush, 1);
                check("rdy_flush", br_ready, 0);
                tick();
            end
        end
        check("flush_off", flush, 0);
        check("ready_after", br_ready, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        flag_valid = 1'b0;
        flag_zero  = 1'b0;
        flag_sign  = 1'b0;
        br_valid   = 1'b0;
        br_op      = 3'd0;
        br_pc      = '0;
        br_target  = '0;
        m_z = 0; m_s = 0; m_fresh = 0;
        m_total = 0; m_taken = 0;
        tick();
        tick();
        check("rst_ready", br_ready, 1);
        check("rst_pcv", pc_valid, 0);
        check("rst_pc", pc_next, 0);
        check("rst_taken", br_taken, 0);
        check("rst_flush", flush, 0);
        rst_n = 1'b1;
        tick();

        // 1: Z=1 then BEQ, taken with 2-cycle flush
        set_flags(1, 0);
        do_branch(3'd0, 20'h00010, 20'h00100, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 2: BNE waits for flags arriving three cycles later
        do_branch(3'd1, 20'h00020, 20'h00400, 0, 0, 0, 2, 0, 0, 0, 0, 0);

        // 3: BNS with S=1 at the top of the PC space wraps to zero
        set_flags(0, 1);
        do_branch(3'd3, 20'hFFFFF, 20'h12345, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // 4: same-cycle Z=0 overrides stale Z=1
        set_flags(1, 0);
        do_branch(3'd0, 20'h00200, 20'h00300, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // 5: reset while waiting for flags
        br_valid = 1'b1;
        br_op    = 3'd0;
        br_pc    = 20'h00500;
        tick();
        br_valid = 1'b0;
        check("r5_wait_pcv", pc_valid, 0);
        check("r5_wait_rdy", br_ready, 0);
        tick();
        rst_n = 1'b0;
        tick();
        check("r5_rst_pcv", pc_valid, 0);
        rst_n = 1'b1;
        m_z = 0; m_s = 0; m_fresh = 0;
        m_total = 0; m_taken = 0;
        tick();
        check("r5_ready", br_ready, 1);
        check("r5_pcv", pc_valid, 0);
        check("r5_pc", pc_next, 0);
        check("r5_flush", flush, 0);
        do_branch(3'd0, 20'h00600, 20'h00700, 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // 6: op 6 and JMP never wait and leave fresh alone
        do_branch(3'd6, 20'h00800, 20'h00900, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_branch(3'd4, 20'h00A00, 20'h00B00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_branch(3'd2, 20'h00C00, 20'h00D00, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        set_flags(0, 1);
        do_branch(3'd4, 20'h00E00, 20'h00F00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        do_branch(3'd2, 20'h01000, 20'h02000, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // New flags during the resolve cycle keep fresh set
        set_flags(1, 1);
        do_branch(3'd0, 20'h03000, 20'h04000, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        do_branch(3'd1, 20'h05000, 20'h06000, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [19:0] pc, tgt;
            if ($urandom_range(0, 1) == 1)
                set_flags(1'($urandom), 1'($urandom));
            op  = 3'($urandom_range(0, 7));
            pc  = 20'($urandom);
            tgt = 20'($urandom);
            do_branch(op, pc, tgt,
                      $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 4), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 4) == 0, 1'($urandom), 1'($urandom));
        end

`ifdef BRANCH_STATS_EN
        check("stat_total", stat_total, 32'(m_total));
        check("stat_taken", stat_taken, 32'(m_taken));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
